// File: rtl/sumador_seq_ctrl.sv
// sumador_seq_ctrl
// Sequencer for the 8-bit counter/adder unit. It clears the counter and issues
// a programmed number of single-cycle enable pulses at a prescaled rate. It then
// checks the counter's final value and carry against its own pulse count.
// Runs can be one-shot or periodic.
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   start           : request a run; only looked at in IDLE
//   stop            : abort any run; returns to IDLE with no done pulse
//   mode_periodic   : restart after each DONE (latched on start)
//   limit           : enable pulses per run (latched on start)
//   prescale        : pulse spacing is prescale+1 cycles (latched on start)
//   cnt_val/cnt_cout: counter value and carry, checked against the pulse count
//   cnt_en/cnt_clr  : enable pulse and synchronous clear toward the counter
//   busy/done/err   : not-idle, end-of-run pulse, sticky check failure
module sumador_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_periodic,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] cnt_val,
  input  logic             cnt_cout,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             periodic_q, periodic_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] issued_q, issued_d;
  logic             err_q, err_d;

  logic             pulse;
  logic [WIDTH-1:0] issued_inc;

  assign pulse      = (state_q == S_RUN) && (pre_q == prescale_q);
  // issued never exceeds limit_q-1 before the last pulse, so +1 cannot wrap.
  assign issued_inc = issued_q + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      limit_q    <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      pre_q      <= '0;
      issued_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      periodic_q <= periodic_d;
      pre_q      <= pre_d;
      issued_q   <= issued_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    periodic_d = periodic_q;
    pre_d      = pre_q;
    issued_d   = issued_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          limit_d    = limit;
          prescale_d = prescale;
          periodic_d = mode_periodic;
          err_d      = 1'b0;
          pre_d      = '0;
          issued_d   = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        pre_d    = '0;
        issued_d = '0;
        state_d  = (limit_q == '0) ? S_SETTLE : S_RUN;
      end
      S_RUN: begin
        if (cnt_cout) err_d = 1'b1;
        if (pulse) begin
          pre_d    = '0;
          issued_d = issued_inc;
          if (issued_inc == limit_q) state_d = S_SETTLE;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      S_SETTLE: begin
        // Counter has had one cycle to absorb the last enable.
        if (cnt_cout || (cnt_val != limit_q)) err_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = periodic_q ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything except reset; err is kept.
    if (stop && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign cnt_clr = (state_q == S_LOAD);
  assign cnt_en  = pulse;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign err     = err_q;

endmodule

// File: tb/tb_sumador_seq_ctrl.sv
module tb_sumador_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, mode_periodic;
  logic [7:0] limit, prescale;
  logic [7:0] cnt_val;
  logic       cnt_cout;
  logic       cnt_en, cnt_clr, busy, done, err;

  always #5 clk = ~clk;

  sumador_seq_ctrl #(.WIDTH(8), .PRE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode_periodic(mode_periodic), .limit(limit), .prescale(prescale),
    .cnt_val(cnt_val), .cnt_cout(cnt_cout),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done), .err(err)
  );

  // Counter model: ideal 8-bit counter, with optional dropped enable,
  // value offset and forced carry to provoke the checker.
  logic [7:0] cval;
  int         en_n;
  int         drop_idx;
  logic [7:0] bias;
  logic       force_cout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cval <= 8'd0;
      en_n <= 0;
    end else if (cnt_clr) begin
      cval <= 8'd0;
    end else if (cnt_en) begin
      en_n <= en_n + 1;
      if (en_n + 1 != drop_idx) cval <= cval + 8'd1;
    end
  end
  assign cnt_val  = cval + bias;
  assign cnt_cout = force_cout;

  int nvec = 0;
  int nmis = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle and sample; every enable pulse is matched against the
  // scoreboard of expected pulse cycles.
  task automatic tick(input int c);
    @(posedge clk);
    #1;
    if (cnt_en) begin
      if (exp_q.size() == 0) chk("pulse_unexpected", c, -1);
      else chk("pulse_cycle", c, exp_q.pop_front());
    end
  endtask

  task automatic push_pulses(input int l, input int p, input int base);
    for (int k = 1; k <= l; k++) exp_q.push_back(base + p + (k - 1) * (p + 1));
  endtask

  typedef struct {
    int lim;
    int pre;
    int bias;
    int cout;
    int exp_done;
    int exp_err;
  } vec_t;

  // Drives start in the current cycle (cycle 0), then scrambles the inputs to
  // show they were latched, and checks clear, pulses, done, busy and err.
  task automatic run_vec(input vec_t v);
    int done_c, ndone, clr_c;
    limit         = 8'(v.lim);
    prescale      = 8'(v.pre);
    mode_periodic = 1'b0;
    bias          = 8'(v.bias);
    force_cout    = v.cout[0];
    start         = 1'b1;
    exp_q.delete();
    push_pulses(v.lim, v.pre, 2);
    done_c = -1; ndone = 0; clr_c = -1;
    for (int c = 1; c <= v.exp_done + 3; c++) begin
      tick(c);
      if (c == 1) begin
        start         = 1'b0;
        limit         = ~limit;
        prescale      = 8'd0;
        mode_periodic = 1'b1;
      end
      if (cnt_clr && clr_c < 0) clr_c = c;
      if (done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (c == v.exp_done + 1) chk("busy_after_done", int'(busy), 0);
    end
    chk("clr_cycle", clr_c, 1);
    chk("done_cycle", done_c, v.exp_done);
    chk("done_count", ndone, 1);
    chk("pulses_left", exp_q.size(), 0);
    chk("err_final", int'(err), v.exp_err);
    force_cout = 1'b0;
    bias       = 8'd0;
  endtask

  vec_t vt[8];

  initial begin
    int np, nd;
    vt[0] = '{3,   0,   0, 0, 6,     0};
    vt[1] = '{2,   2,   0, 0, 9,     0};
    vt[2] = '{0,   0,   1, 0, 3,     1};
    vt[3] = '{0,   5,   0, 0, 3,     0};
    vt[4] = '{1,   0,   0, 0, 4,     0};
    vt[5] = '{5,   3,   0, 0, 23,    0};
    vt[6] = '{4,   1,   0, 1, 11,    1};
    vt[7] = '{255, 255, 0, 0, 65283, 0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode_periodic = 1'b0;
    limit = 8'd0; prescale = 8'd0; bias = 8'd0; force_cout = 1'b0; drop_idx = 0;
    #1;
    chk("rst_outputs", {cnt_en, cnt_clr, busy, done, err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-run: limit=10, prescale=0, reset during cycle 5 (RUN).
    limit = 8'd10; prescale = 8'd0; start = 1'b1;
    exp_q.delete();
    push_pulses(10, 0, 2);
    for (int c = 1; c <= 5; c++) begin
      tick(c);
      start = 1'b0;
    end
    chk("busy_before_rst", int'(busy), 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_run_outputs", {cnt_en, cnt_clr, busy, done, err}, 0);
    exp_q.delete();
    @(negedge clk) rst = 1'b0;
    np = 0; nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      np += int'(cnt_en) + int'(busy);
      nd += int'(done);
    end
    chk("post_rst_activity", np, 0);
    chk("post_rst_done", nd, 0);

    // Table of one-shot runs.
    for (int i = 0; i < 8; i++) run_vec(vt[i]);

    // Stop at cycle 4 of a limit=10 run.
    limit = 8'd10; prescale = 8'd0; mode_periodic = 1'b0; start = 1'b1;
    exp_q.delete();
    push_pulses(3, 0, 2);
    nd = 0;
    for (int c = 1; c <= 15; c++) begin
      tick(c);
      start = 1'b0;
      if (c == 4) stop = 1'b1;
      if (c == 5) begin
        chk("stop_busy", int'(busy), 0);
        chk("stop_en", int'(cnt_en), 0);
        stop = 1'b0;
      end
      nd += int'(done);
    end
    chk("stop_no_done", nd, 0);
    chk("stop_pulses_left", exp_q.size(), 0);
    run_vec('{1, 0, 0, 0, 4, 0});

    // start together with stop in IDLE is ignored.
    start = 1'b1; stop = 1'b1; limit = 8'd2;
    tick(1);
    chk("start_stop_idle", int'(busy), 0);
    start = 1'b0; stop = 1'b0;
    tick(2);
    chk("start_stop_idle2", int'(busy), 0);

    // Periodic, limit=3, second enable dropped in the first run.
    drop_idx = en_n + 2;
    limit = 8'd3; prescale = 8'd0; mode_periodic = 1'b1; start = 1'b1;
    exp_q.delete();
    push_pulses(3, 0, 2);
    push_pulses(3, 0, 8);
    push_pulses(3, 0, 14);
    for (int c = 1; c <= 17; c++) begin
      tick(c);
      start = 1'b0; mode_periodic = 1'b0;
      if (c == 6)  chk("per_done1", int'(done), 1);
      if (c == 6)  chk("per_err1", int'(err), 1);
      if (c == 7)  chk("per_reload", int'(cnt_clr), 1);
      if (c == 12) chk("per_done2", int'(done), 1);
      if (c == 12) chk("per_err2", int'(err), 1);
      if (c == 17) stop = 1'b1;
    end
    tick(18);
    stop = 1'b0;
    drop_idx = 0;
    chk("per_stop_busy", int'(busy), 0);
    chk("per_err_kept", int'(err), 1);
    chk("per_pulses_left", exp_q.size(), 0);
    run_vec('{1, 0, 0, 0, 4, 0});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
